snake_head_stepper: RTL and testbench
=====================================

// Module: snake_head_stepper
// PURPOSE
//  Owns the snake head coordinate on the 32x32 playfield. A prescaler turns the
//  system clock into game ticks; on each tick the head moves one cell in the
//  committed direction. Feeds the five-bit subtract/add datapath (moves toward
//  0 subtract 1). Feeds head_x/head_y/step_pulse to the body/collision stage.
// PARAMETERS
//  TICK_DIV  12500000  clocks per game step (>=2)
//  WRAP      1         1: wrap at edges (0<->31); 0: edge exit = wall hit
//  START_X   16        head X after reset (0..31)
//  START_Y   16        head Y after reset (0..31)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  synchronous, active-high reset
//  en          in   1  1 = run/start, 0 = pause prescaler
//  dir_req     in   2  requested direction: 00 up, 01 right, 10 down, 11 left
//  dir_valid   in   1  dir_req valid this cycle
//  dir_ready   out  1  1 when a request can be accepted
//  head_x      out  5  current head column
//  head_y      out  5  current head row (0 = top)
//  dir         out  2  direction used by the most recent step
//  step_pulse  out  1  one-cycle pulse: head_x/head_y just updated
//  wall_hit    out  1  sticky; head tried to leave grid (WRAP=0 only)
// BEHAVIOUR
//  Reset (rst=1 at edge, overrides all): state IDLE, head=(START_X,START_Y),
//   dir=01, pend_dir=01, count=0, step_pulse=0, wall_hit=0, dir_ready=0.
//  States: IDLE -> RUN when en=1 at an edge; RUN -> DEAD on wall hit;
//   DEAD left only by rst. en=0 in RUN holds count and head (pause); no steps.
//  dir_ready = 1 in RUN only (independent of en). Transfer = dir_valid&dir_ready.
//  Accepted request: if dir_req == dir ^ 2'b10 (reversal of committed dir) it is
//   discarded; else pend_dir <= dir_req. Several accepts between steps: last
//   non-reversal wins.
//  Prescaler: in RUN & en, count increments each clock; at count==TICK_DIV-1,
//   count<=0 and step occurs on that edge. First step TICK_DIV clocks after
//   entering RUN.
//  Step (on edge): dir<=pend_dir; head moves per pend_dir:
//   up y-1, down y+1, left x-1, right x+1, all 5-bit modulo 32.
//   step_pulse=1 for exactly the following cycle, where new head is visible.
//  Step and accepted request on the same edge: step uses pend_dir held before the
//   edge; the new request updates pend_dir for the next step, reversal check
//   against dir held before the edge.
//  WRAP=1: 0-1 -> 31, 31+1 -> 0, no flag.
//  WRAP=0: step that would wrap does not move head; wall_hit<=1, state<=DEAD,
//   dir still updates, step_pulse still pulses. DEAD: no steps, dir_ready=0.
//  rst mid-step or in DEAD: full reset values next cycle; no step_pulse.
//  Outputs registered; no combinational path from inputs to outputs except
//   none (dir_ready is a function of state only).
// TESTING (TICK_DIV=4, START 16/16 unless noted)
//  1 rst then en=1 -> step_pulse every 4 clocks; head_x 17,18,19; head_y=16.
//  2 dir_req=11 (left) while dir=01 -> discarded; dir_req=00 then 10 in same
//    tick window -> next step y=17 (down wins; check vs committed 01).
//  3 WRAP=1, START_X=31, dir right -> after 1 step head_x=0; up from y=0 -> 31.
//  4 WRAP=0, START_Y=0, req up -> step: head_y stays 0, wall_hit=1, dir_ready=0,
//    no further step_pulse for 20 clocks; rst -> wall_hit=0, head=(16,0).
//  5 en=0 for 10 clocks at count=2 -> no movement; en=1 -> step 2 clocks later.
//  6 dir_valid on exact step edge with req=10 from dir=01 -> that step moves
//    right; following step moves down; rst asserted on a step edge -> head=START,
//    step_pulse=0 next cycle.

Source files
------------

// File: rtl/snake_head_stepper.sv
// Snake head position stepper: prescales the system clock into game ticks and
// moves the head one cell per tick in the committed direction.
module snake_head_stepper #(
    parameter int unsigned TICK_DIV = 12500000,
    parameter int unsigned WRAP     = 1,
    parameter int unsigned START_X  = 16,
    parameter int unsigned START_Y  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] dir_req,
    input  logic       dir_valid,
    output logic       dir_ready,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [1:0] dir,
    output logic       step_pulse,
    output logic       wall_hit
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DEAD = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [1:0]       pend_dir;
    logic             step_c;
    logic             accept_c;
    logic             edge_c;
    logic [4:0]       move_x_c;
    logic [4:0]       move_y_c;

    // Candidate next head cell for the pending direction, and whether it leaves the grid
    always_comb begin
        move_x_c = head_x;
        move_y_c = head_y;
        edge_c   = 1'b0;
        case (pend_dir)
            DIR_UP: begin
                move_y_c = head_y - 5'd1;
                edge_c   = (head_y == 5'd0);
            end
            DIR_RIGHT: begin
                move_x_c = head_x + 5'd1;
                edge_c   = (head_x == 5'd31);
            end
            DIR_DOWN: begin
                move_y_c = head_y + 5'd1;
                edge_c   = (head_y == 5'd31);
            end
            DIR_LEFT: begin
                move_x_c = head_x - 5'd1;
                edge_c   = (head_x == 5'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, prescaler and step/accept strobes
    always_comb begin
        state_next = state;
        count_next = count;
        step_c     = 1'b0;
        accept_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                accept_c = dir_valid;
                if (en) begin
                    if (count == CNT_LAST) begin
                        count_next = '0;
                        step_c     = 1'b1;
                        if (WRAP == 0 && edge_c) begin
                            state_next = S_DEAD;
                        end
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            head_x     <= 5'(START_X);
            head_y     <= 5'(START_Y);
            dir        <= DIR_RIGHT;
            pend_dir   <= DIR_RIGHT;
            step_pulse <= 1'b0;
            wall_hit   <= 1'b0;
            dir_ready  <= 1'b0;
        end else begin
            count      <= count_next;
            step_pulse <= step_c;
            dir_ready  <= (state_next == S_RUN);
            if (step_c) begin
                dir <= pend_dir;
                if (WRAP == 0 && edge_c) begin
                    wall_hit <= 1'b1;
                end else begin
                    head_x <= move_x_c;
                    head_y <= move_y_c;
                end
            end
            // Reversal is judged against the direction committed before this edge
            if (accept_c && (dir_req != (dir ^ 2'b10))) begin
                pend_dir <= dir_req;
            end
        end
    end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Bench for snake_head_stepper: three instances (wrap centre, wrap corner,
// wall mode) checked every cycle against a behavioural model.
module tb_snake_head_stepper;

    localparam int DIV = 4;
    localparam int NI  = 3;
    localparam int P_WRAP [NI] = '{1, 1, 0};
    localparam int P_SX   [NI] = '{16, 31, 16};
    localparam int P_SY   [NI] = '{16, 0, 0};

    logic       clk = 1'b0;
    logic       rst  [NI];
    logic       en   [NI];
    logic       dv   [NI];
    logic [1:0] dreq [NI];
    logic       dr   [NI];
    logic [4:0] hx   [NI];
    logic [4:0] hy   [NI];
    logic [1:0] hd   [NI];
    logic       sp   [NI];
    logic       wh   [NI];

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    // model: st 0 idle, 1 running, 2 dead
    int m_st [NI];
    int m_cnt[NI];
    int m_x  [NI];
    int m_y  [NI];
    int m_dir[NI];
    int m_pnd[NI];
    int m_sp [NI];
    int m_wh [NI];

    always #5 clk = ~clk;

    snake_head_stepper #(.TICK_DIV(DIV), .WRAP(1), .START_X(16), .START_Y(16)) u0 (
        .clk(clk), .rst(rst[0]), .en(en[0]), .dir_req(dreq[0]), .dir_valid(dv[0]),
        .dir_ready(dr[0]), .head_x(hx[0]), .head_y(hy[0]), .dir(hd[0]),
        .step_pulse(sp[0]), .wall_hit(wh[0]));

    snake_head_stepper #(.TICK_DIV(DIV), .WRAP(1), .START_X(31), .START_Y(0)) u1 (
        .clk(clk), .rst(rst[1]), .en(en[1]), .dir_req(dreq[1]), .dir_valid(dv[1]),
        .dir_ready(dr[1]), .head_x(hx[1]), .head_y(hy[1]), .dir(hd[1]),
        .step_pulse(sp[1]), .wall_hit(wh[1]));

    snake_head_stepper #(.TICK_DIV(DIV), .WRAP(0), .START_X(16), .START_Y(0)) u2 (
        .clk(clk), .rst(rst[2]), .en(en[2]), .dir_req(dreq[2]), .dir_valid(dv[2]),
        .dir_ready(dr[2]), .head_x(hx[2]), .head_y(hy[2]), .dir(hd[2]),
        .step_pulse(sp[2]), .wall_hit(wh[2]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Game rules applied to the values present just before a rising edge
    task automatic model_edge(input int i);
        int  od;
        int  op;
        int  dx;
        int  dy;
        int  nx;
        int  ny;
        bit  step;
        if (rst[i]) begin
            m_st[i] = 0; m_cnt[i] = 0; m_x[i] = P_SX[i]; m_y[i] = P_SY[i];
            m_dir[i] = 1; m_pnd[i] = 1; m_sp[i] = 0; m_wh[i] = 0;
            return;
        end
        od = m_dir[i];
        op = m_pnd[i];
        step = 1'b0;
        m_sp[i] = 0;
        if (m_st[i] == 0) begin
            if (en[i]) m_st[i] = 1;
        end else if (m_st[i] == 1) begin
            if (dv[i] && int'(dreq[i]) != (od ^ 2)) m_pnd[i] = int'(dreq[i]);
            if (en[i]) begin
                if (m_cnt[i] == DIV - 1) begin
                    m_cnt[i] = 0;
                    step = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        if (step) begin
            dx = (op == 1) ? 1 : (op == 3) ? -1 : 0;
            dy = (op == 2) ? 1 : (op == 0) ? -1 : 0;
            nx = m_x[i] + dx;
            ny = m_y[i] + dy;
            m_dir[i] = op;
            m_sp[i] = 1;
            if (nx < 0 || nx > 31 || ny < 0 || ny > 31) begin
                if (P_WRAP[i] != 0) begin
                    m_x[i] = (nx + 32) % 32;
                    m_y[i] = (ny + 32) % 32;
                end else begin
                    m_wh[i] = 1;
                    m_st[i] = 2;
                end
            end else begin
                m_x[i] = nx;
                m_y[i] = ny;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) model_edge(i);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d head_x", i), int'(hx[i]), m_x[i]);
                chk($sformatf("u%0d head_y", i), int'(hy[i]), m_y[i]);
                chk($sformatf("u%0d dir", i), int'(hd[i]), m_dir[i]);
                chk($sformatf("u%0d step_pulse", i), int'(sp[i]), m_sp[i]);
                chk($sformatf("u%0d wall_hit", i), int'(wh[i]), m_wh[i]);
                chk($sformatf("u%0d dir_ready", i), int'(dr[i]), (m_st[i] == 1) ? 1 : 0);
            end
        end
    end

    initial begin
        #6 chk_on = 1'b1;
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; dv[i] = 1'b0; dreq[i] = 2'b00;
        end
        tick(1);
        chk("reset x", int'(hx[0]), 16);
        chk("reset y", int'(hy[0]), 16);
        chk("reset dir", int'(hd[0]), 1);
        chk("reset pulse", int'(sp[0]), 0);
        chk("reset ready", int'(dr[0]), 0);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;

        // straight run to the right
        en[0] = 1'b1;
        tick(5);
        chk("t1 x17", int'(hx[0]), 17);
        chk("t1 pulse", int'(sp[0]), 1);
        tick(4);
        chk("t1 x18", int'(hx[0]), 18);
        tick(4);
        chk("t1 x19", int'(hx[0]), 19);
        chk("t1 y16", int'(hy[0]), 16);

        // reversal discarded, then up then down: down wins
        dv[0] = 1'b1; dreq[0] = 2'b11; tick(1);
        dreq[0] = 2'b00; tick(1);
        dreq[0] = 2'b10; tick(1);
        dv[0] = 1'b0; tick(1);
        chk("t2 y17", int'(hy[0]), 17);
        chk("t2 x19", int'(hx[0]), 19);
        chk("t2 dir down", int'(hd[0]), 2);

        // pause mid-window
        tick(2);
        en[0] = 1'b0; tick(10);
        chk("t5 paused y", int'(hy[0]), 17);
        en[0] = 1'b1; tick(1);
        chk("t5 no early step", int'(sp[0]), 0);
        tick(1);
        chk("t5 y18", int'(hy[0]), 18);
        chk("t5 pulse", int'(sp[0]), 1);

        // request landing exactly on a step edge
        dv[0] = 1'b1; dreq[0] = 2'b01; tick(1);
        dv[0] = 1'b0; tick(3);
        chk("t6 x20", int'(hx[0]), 20);
        tick(3);
        dv[0] = 1'b1; dreq[0] = 2'b10; tick(1);
        dv[0] = 1'b0;
        chk("t6 x21", int'(hx[0]), 21);
        chk("t6 dir right", int'(hd[0]), 1);
        tick(4);
        chk("t6 y19", int'(hy[0]), 19);
        chk("t6 dir down", int'(hd[0]), 2);
        tick(3);
        rst[0] = 1'b1; tick(1);
        rst[0] = 1'b0;
        chk("t6 rst x", int'(hx[0]), 16);
        chk("t6 rst y", int'(hy[0]), 16);
        chk("t6 rst pulse", int'(sp[0]), 0);

        // wrap at the corner
        en[1] = 1'b1; tick(5);
        chk("t3 wrap x0", int'(hx[1]), 0);
        dv[1] = 1'b1; dreq[1] = 2'b00; tick(1);
        dv[1] = 1'b0; tick(3);
        chk("t3 wrap y31", int'(hy[1]), 31);
        chk("t3 x0", int'(hx[1]), 0);

        // wall mode: step up off the top row
        en[2] = 1'b1; tick(1);
        chk("t4 ready run", int'(dr[2]), 1);
        dv[2] = 1'b1; dreq[2] = 2'b00; tick(1);
        dv[2] = 1'b0; tick(3);
        chk("t4 y0", int'(hy[2]), 0);
        chk("t4 wall", int'(wh[2]), 1);
        chk("t4 pulse", int'(sp[2]), 1);
        chk("t4 dir up", int'(hd[2]), 0);
        chk("t4 ready dead", int'(dr[2]), 0);
        for (int k = 0; k < 20; k++) begin
            tick(1);
            chk("t4 dead no pulse", int'(sp[2]), 0);
        end
        rst[2] = 1'b1; tick(1);
        rst[2] = 1'b0;
        chk("t4 rst wall", int'(wh[2]), 0);
        chk("t4 rst x", int'(hx[2]), 16);
        chk("t4 rst y", int'(hy[2]), 0);

        // randomized traffic on all instances
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                rst[i]  = ($urandom_range(0, 199) == 0);
                en[i]   = ($urandom_range(0, 9) != 0);
                dv[i]   = ($urandom_range(0, 3) == 0);
                dreq[i] = 2'($urandom_range(0, 3));
            end
            tick(1);
        end
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0; en[i] = 1'b0; dv[i] = 1'b0;
        end
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
